// File: rtl/cordic_req_arbiter.sv
// rtl/cordic_req_arbiter.sv - round-robin arbiter/sequencer sharing one CORDIC engine
module cordic_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*24-1:0] req_angle,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [23:0]           res_sin,
  output logic [23:0]           res_cos,
  output logic                  res_err,
  output logic                  busy,
  output logic                  eng_start,
  output logic [23:0]           eng_angle,
  input  logic                  eng_ready,
  input  logic [23:0]           eng_sin,
  input  logic [23:0]           eng_cos
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

  state_t           state;
  logic [IDW-1:0]   cur;
  logic [IDW-1:0]   last;
  logic [CW-1:0]    cnt;
  logic             win_valid;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   rr_sel;
  int               rr_idx;
  logic [23:0]      angle_arr [NUM_REQ];

  // Unpack the requester angle bus so the winner's slice can be picked by id.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      angle_arr[k] = req_angle[24*k +: 24];
    end
  end

  // Round-robin search starting just after the last served requester.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    rr_idx    = 0;
    rr_sel    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = int'(last) + i;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      rr_sel = IDW'(rr_idx);
      if (!win_valid && req[rr_sel]) begin
        win_valid = 1'b1;
        win_id    = rr_sel;
      end
    end
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cur       <= '0;
      last      <= IDW'(NUM_REQ - 1);
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      res_sin   <= '0;
      res_cos   <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      eng_start <= 1'b0;
      eng_angle <= '0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      eng_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            state     <= S_ISSUE;
            cur       <= win_id;
            eng_angle <= angle_arr[win_id];
            gnt       <= NUM_REQ'(1) << win_id;
            eng_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_ready) begin
            res_sin <= eng_sin;
            res_cos <= eng_cos;
            res_err <= 1'b0;
            done    <= NUM_REQ'(1) << cur;
            state   <= S_DELIVER;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            res_sin <= '0;
            res_cos <= '0;
            res_err <= 1'b1;
            done    <= NUM_REQ'(1) << cur;
            state   <= S_DELIVER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DELIVER: begin
          last  <= cur;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// tb/tb_cordic_req_arbiter.sv - directed self-checking bench for cordic_req_arbiter
module tb_cordic_req_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [95:0] req_angle;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [23:0] res_sin;
  logic [23:0] res_cos;
  logic        res_err;
  logic        busy;
  logic        eng_start;
  logic [23:0] eng_angle;
  logic        eng_ready;
  logic [23:0] eng_sin;
  logic [23:0] eng_cos;

  logic        mdl_ready;
  logic [23:0] mdl_sin;
  logic [23:0] mdl_cos;
  logic        man_ready;
  logic [23:0] man_sin;
  logic [23:0] man_cos;
  logic        eng_never;

  int checks;
  int errors;

  logic [23:0] ang   [4];
  logic [23:0] exp_s [4];
  logic [23:0] exp_c [4];

  typedef struct {
    logic [3:0] req;
    logic [3:0] req_after;
    logic       never;
    int         exp_id;
    logic       exp_err;
    int         exp_cyc;
  } vec_t;

  vec_t vecs [11];

  assign eng_ready = mdl_ready | man_ready;
  assign eng_sin   = man_ready ? man_sin : mdl_sin;
  assign eng_cos   = man_ready ? man_cos : mdl_cos;

  cordic_req_arbiter #(.NUM_REQ(4), .TIMEOUT(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_angle (req_angle),
    .gnt       (gnt),
    .done      (done),
    .res_sin   (res_sin),
    .res_cos   (res_cos),
    .res_err   (res_err),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_angle (eng_angle),
    .eng_ready (eng_ready),
    .eng_sin   (eng_sin),
    .eng_cos   (eng_cos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural engine: ready 18 cycles after the start pulse, real-valued sin/cos.
  initial begin
    logic signed [23:0] a;
    real r;
    mdl_ready = 1'b0;
    mdl_sin   = '0;
    mdl_cos   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (eng_start && !eng_never) begin
        a = eng_angle;
        r = $itor(a) / 65536.0;
        repeat (18) @(posedge clk);
        #1;
        mdl_ready = 1'b1;
        mdl_sin   = 24'($rtoi($sin(r) * 65536.0 + (($sin(r) >= 0.0) ? 0.5 : -0.5)));
        mdl_cos   = 24'($rtoi($cos(r) * 65536.0 + (($cos(r) >= 0.0) ? 0.5 : -0.5)));
        @(posedge clk);
        #1;
        mdl_ready = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input logic [23:0] act, input logic [23:0] exp);
    int d;
    checks++;
    d = int'(signed'(act)) - int'(signed'(exp));
    if (d > 4 || d < -4) begin
      errors++;
      $display("FAIL %s: got 0x%06h, expected 0x%06h +-4", nm, act, exp);
    end
  endtask

  // One full operation starting in an IDLE cycle (cycle 0 = this cycle).
  task automatic run_op(input vec_t v);
    int n;
    req       = v.req;
    eng_never = v.never;
    tick();
    chk("gnt", {28'd0, gnt}, 32'd1 << v.exp_id);
    chk("eng_start", {31'd0, eng_start}, 32'd1);
    chk("busy_c1", {31'd0, busy}, 32'd1);
    chk("eng_angle", {8'd0, eng_angle}, {8'd0, ang[v.exp_id]});
    req = v.req_after;
    tick();
    chk("gnt_c2", {28'd0, gnt, 3'd0, eng_start}, 32'd0);
    n = 2;
    while (done == 4'd0 && n < 60) begin
      tick();
      n++;
    end
    chk("done_cycle", n, v.exp_cyc);
    chk("done_onehot", {28'd0, done}, 32'd1 << v.exp_id);
    chk("res_err", {31'd0, res_err}, {31'd0, v.exp_err});
    if (v.exp_err) begin
      chk("res_zero", {res_sin[15:0], res_cos[15:0]}, 32'd0);
    end else begin
      chk_tol("res_sin", res_sin, exp_s[v.exp_id]);
      chk_tol("res_cos", res_cos, exp_c[v.exp_id]);
    end
    tick();
    chk("after_deliver", {27'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int seen;
    vec_t rv;
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    req       = '0;
    man_ready = 1'b0;
    man_sin   = '0;
    man_cos   = '0;
    eng_never = 1'b0;

    ang[0] = 24'h00C90F; exp_s[0] = 24'h00B505; exp_c[0] = 24'h00B505;
    ang[1] = 24'h000000; exp_s[1] = 24'h000000; exp_c[1] = 24'h010000;
    ang[2] = 24'h019220; exp_s[2] = 24'h010000; exp_c[2] = 24'h000000;
    ang[3] = 24'hFF36F1; exp_s[3] = 24'hFF4AFB; exp_c[3] = 24'h00B505;
    req_angle = {ang[3], ang[2], ang[1], ang[0]};

    //          req      after    never exp_id err  cyc
    vecs[0]  = '{4'b0001, 4'b0000, 1'b0, 0, 1'b0, 20};
    vecs[1]  = '{4'b1111, 4'b1111, 1'b0, 1, 1'b0, 20};
    vecs[2]  = '{4'b1111, 4'b1111, 1'b0, 2, 1'b0, 20};
    vecs[3]  = '{4'b1111, 4'b1111, 1'b0, 3, 1'b0, 20};
    vecs[4]  = '{4'b1111, 4'b0000, 1'b0, 0, 1'b0, 20};
    vecs[5]  = '{4'b0100, 4'b0000, 1'b0, 2, 1'b0, 20};
    vecs[6]  = '{4'b1011, 4'b1011, 1'b0, 3, 1'b0, 20};
    vecs[7]  = '{4'b1011, 4'b1011, 1'b0, 0, 1'b0, 20};
    vecs[8]  = '{4'b1011, 4'b0000, 1'b0, 1, 1'b0, 20};
    vecs[9]  = '{4'b0010, 4'b0000, 1'b1, 1, 1'b1, 34};
    vecs[10] = '{4'b0001, 4'b0000, 1'b0, 0, 1'b0, 20};

    repeat (3) tick();
    chk("reset_ctl", {24'd0, gnt, done}, 32'd0);
    chk("reset_flags", {29'd0, busy, eng_start, res_err}, 32'd0);
    chk("reset_res", {8'd0, res_sin ^ res_cos ^ eng_angle}, 32'd0);
    chk("reset_res_or", {8'd0, res_sin | res_cos | eng_angle}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Vector 0 runs after reset: requester 0 first; vectors 1..4 hold all four
    // so fairness continues from last=0.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i]);
    end

    // Stray ready while idle must not strobe or alter held results.
    man_sin   = 24'h111111;
    man_cos   = 24'h222222;
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    seen = 0;
    repeat (4) begin
      tick();
      if (done != 4'd0) seen++;
    end
    chk("stray_no_done", seen, 0);
    chk_tol("stray_sin_held", res_sin, 24'h00B505);
    chk_tol("stray_cos_held", res_cos, 24'h00B505);

    // Ready coinciding with counter == TIMEOUT-1: data wins, no error.
    eng_never = 1'b1;
    req = 4'b0001;
    tick();
    chk("sim_gnt", {28'd0, gnt}, 32'd1);
    req = 4'b0000;
    repeat (32) tick();
    chk("sim_no_early_done", {28'd0, done}, 32'd0);
    man_sin   = 24'h123456;
    man_cos   = 24'h654321;
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    chk("sim_done", {28'd0, done}, 32'd1);
    chk("sim_err", {31'd0, res_err}, 32'd0);
    chk("sim_data", {res_sin[15:0], res_cos[15:0]}, 32'h34564321);
    chk("sim_sin_hi", {24'd0, res_sin[23:16]}, 32'h12);
    tick();
    chk("sim_idle", {31'd0, busy}, 32'd0);
    eng_never = 1'b0;

    // Reset at cycle 10 of an operation.
    req = 4'b0001;
    tick();
    chk("rst_op_gnt", {28'd0, gnt}, 32'd1);
    req = 4'b0000;
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    chk("rst_outs", {22'd0, gnt, done, busy, eng_start}, 32'd0);
    chk("rst_res", {7'd0, res_err, res_sin | res_cos | eng_angle}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    seen = 0;
    repeat (25) begin
      tick();
      if (done != 4'd0) seen++;
    end
    chk("rst_no_done", seen, 0);
    rv = '{4'b1111, 4'b0000, 1'b0, 0, 1'b0, 20};
    run_op(rv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
